// File: rtl/mask_table_seq_if.sv
// Bus bundle for mask_table_seq: config write port plus the masked-data beat stream.
// The master side drives config, start and ready; the slave side is the table sequencer.
interface mask_table_seq_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
);
    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [WIDTH-1:0] cfg_wdata;
    logic             cfg_drop;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_idx;
    logic [WIDTH-1:0] out_data;
    logic             done;
    logic             err;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, start, data_in, out_ready,
        input  cfg_drop, busy, out_valid, out_idx, out_data, done, err
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, start, data_in, out_ready,
        output cfg_drop, busy, out_valid, out_idx, out_data, done, err
    );
endinterface

// File: rtl/mask_table_seq.sv
// Mask table sequencer: on start, streams data_latched & table[i] for i = 0..DEPTH-1.
// Optional per-entry even parity with sticky err is enabled by defining MASK_TBL_PARITY_EN.
module mask_table_seq #(
    parameter int                         WIDTH     = 8,
    parameter int                         DEPTH     = 8,
    parameter int                         AW        = $clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0]     INIT_MASK = 64'hE103073F33C3C337
) (
    input logic              clk,
    input logic              rst,
    mask_table_seq_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] tbl_q [DEPTH];
    logic [WIDTH-1:0] data_q;
    logic [AW-1:0]    idx_q;
    logic             busy_q;
    logic             valid_q;
    logic             done_q;
    logic             drop_q;
    logic             err_q;

    logic [WIDTH-1:0] entry_cur;
    logic             wr_ok;
    logic             accept;
    logic             last_beat;

    // Out-of-range addresses (non-power-of-2 DEPTH) are silently ignored, never dropped.
    assign wr_ok     = bus.cfg_we && (int'(bus.cfg_addr) < DEPTH);
    assign accept    = valid_q && bus.out_ready;
    assign last_beat = (idx_q == AW'(DEPTH - 1));

`ifdef MASK_TBL_PARITY_EN
    logic [DEPTH*WIDTH-1:0] par_flip;
    logic [DEPTH-1:0]       par_q;

    assign par_flip  = '0;
    assign entry_cur = tbl_q[idx_q] ^ par_flip[int'(idx_q)*WIDTH +: WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) par_q[i] <= ^INIT_MASK[i*WIDTH +: WIDTH];
            err_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && wr_ok) par_q[bus.cfg_addr] <= ^bus.cfg_wdata;
            if (state_q == S_SCAN && accept && ((^entry_cur) != par_q[idx_q])) err_q <= 1'b1;
        end
    end
`else
    assign entry_cur = tbl_q[idx_q];
    assign err_q     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= INIT_MASK[i*WIDTH +: WIDTH];
        end else if (state_q == S_IDLE && wr_ok) begin
            tbl_q[bus.cfg_addr] <= bus.cfg_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            drop_q <= wr_ok && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        data_q  <= bus.data_in;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (accept) begin
                        if (last_beat) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Data path is gated by valid so an async reset clears out_data immediately.
    assign bus.out_data  = valid_q ? (data_q & entry_cur) : '0;
    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.cfg_drop  = drop_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mask_table_seq.sv
// Bench for mask_table_seq: directed literal scenarios plus randomized traffic checked
// every cycle against a queue-based model of expected beats.
module tb_mask_table_seq;
    localparam logic [63:0] INIT = 64'hE103073F33C3C337;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mask_table_seq_if #(.WIDTH(8), .AW(3)) bus_if ();
    mask_table_seq mask_tbl_seq (.clk(clk), .rst(rst), .bus(bus_if));

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b1;

    logic [7:0] m_tbl [8];
    logic [7:0] q_d [$];
    int         q_i [$];
    bit         m_done = 1'b0;
    bit         m_drop = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < 24 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.done) seen = 1'b1;
            tick();
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Reference model: a start enqueues all DEPTH expected beats; done follows the last pop.
    always @(negedge clk) begin
        bit ev, eb, nd;
        if (rst) begin
            q_d.delete();
            q_i.delete();
            m_done = 1'b0;
            m_drop = 1'b0;
            for (int i = 0; i < 8; i++) m_tbl[i] = INIT[i*8 +: 8];
            if (chk_en) begin
                chk("rst_valid", 32'(bus_if.out_valid), 32'd0);
                chk("rst_busy",  32'(bus_if.busy),      32'd0);
                chk("rst_data",  32'(bus_if.out_data),  32'd0);
                chk("rst_done",  32'(bus_if.done),      32'd0);
            end
        end else if (chk_en) begin
            ev = (q_d.size() > 0);
            eb = ev || m_done;
            chk("m_valid", 32'(bus_if.out_valid), 32'(ev));
            chk("m_busy",  32'(bus_if.busy),      32'(eb));
            chk("m_done",  32'(bus_if.done),      32'(m_done));
            chk("m_drop",  32'(bus_if.cfg_drop),  32'(m_drop));
            chk("m_err",   32'(bus_if.err),       32'd0);
            if (ev) begin
                chk("m_idx",  32'(bus_if.out_idx),  32'(q_i[0]));
                chk("m_data", 32'(bus_if.out_data), 32'(q_d[0]));
            end
            nd     = 1'b0;
            m_drop = bus_if.cfg_we && eb;
            if (!eb) begin
                if (bus_if.cfg_we) m_tbl[bus_if.cfg_addr] = bus_if.cfg_wdata;
                if (bus_if.start)
                    for (int i = 0; i < 8; i++) begin
                        q_d.push_back(bus_if.data_in & m_tbl[i]);
                        q_i.push_back(i);
                    end
            end else if (ev && bus_if.out_ready) begin
                void'(q_d.pop_front());
                void'(q_i.pop_front());
                if (q_d.size() == 0) nd = 1'b1;
            end
            m_done = nd;
        end
    end

    initial begin
        logic [7:0] lit1 [8] = '{8'h37, 8'hC3, 8'hC3, 8'h33, 8'h3F, 8'h07, 8'h03, 8'hE1};
        logic [7:0] lit2 [8] = '{8'h22, 8'h82, 8'h0A, 8'h22, 8'h2A, 8'h02, 8'h02, 8'hA0};

        bus_if.cfg_we = 1'b0; bus_if.cfg_addr = '0; bus_if.cfg_wdata = '0;
        bus_if.start = 1'b0; bus_if.data_in = '0; bus_if.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_idx",  32'(bus_if.out_idx),  32'd0);
        chk("reset_drop", 32'(bus_if.cfg_drop), 32'd0);
        chk("reset_err",  32'(bus_if.err),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        // Plain scan with all-ones operand exposes the raw table.
        bus_if.start = 1'b1; bus_if.data_in = 8'hFF;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t1_idx",  32'(bus_if.out_idx),  32'(k));
            chk("t1_data", 32'(bus_if.out_data), 32'(lit1[k]));
            tick();
        end
        @(negedge clk);
        chk("t1_done", 32'(bus_if.done), 32'd1);
        chk("t1_err",  32'(bus_if.err),  32'd0);
        tick();

        // Write and start in the same idle cycle: scan must see the new entry.
        bus_if.cfg_we = 1'b1; bus_if.cfg_addr = 3'd2; bus_if.cfg_wdata = 8'h0F;
        bus_if.start = 1'b1; bus_if.data_in = 8'hAA;
        tick();
        bus_if.cfg_we = 1'b0; bus_if.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t2_data", 32'(bus_if.out_data), 32'(lit2[k]));
            tick();
        end
        wait_done("t2_done");

        // Backpressure at idx4 for three cycles.
        bus_if.start = 1'b1; bus_if.data_in = 8'h5A;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t3_idx", 32'(bus_if.out_idx), 32'(k));
            tick();
        end
        bus_if.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t3_hold_idx",  32'(bus_if.out_idx),  32'd4);
            chk("t3_hold_data", 32'(bus_if.out_data), 32'h1A);
            tick();
        end
        bus_if.out_ready = 1'b1;
        for (int k = 4; k < 8; k++) begin
            @(negedge clk);
            chk("t3_idx", 32'(bus_if.out_idx), 32'(k));
            tick();
        end
        @(negedge clk);
        chk("t3_done", 32'(bus_if.done), 32'd1);
        tick();

        // Config write during a scan is dropped and reported.
        bus_if.start = 1'b1; bus_if.data_in = 8'hFF;
        tick();
        bus_if.start = 1'b0;
        bus_if.cfg_we = 1'b1; bus_if.cfg_addr = 3'd0; bus_if.cfg_wdata = 8'h00;
        tick();
        bus_if.cfg_we = 1'b0;
        @(negedge clk);
        chk("t4_drop", 32'(bus_if.cfg_drop), 32'd1);
        tick();
        wait_done("t4_done1");
        bus_if.start = 1'b1; bus_if.data_in = 8'hC6;
        tick();
        bus_if.start = 1'b0;
        @(negedge clk);
        chk("t4_idx0", 32'(bus_if.out_data), 32'h06);
        tick();
        wait_done("t4_done2");

        // Reset mid-scan aborts and restores the initial table.
        bus_if.cfg_we = 1'b1; bus_if.cfg_addr = 3'd6; bus_if.cfg_wdata = 8'h00;
        tick();
        bus_if.cfg_we = 1'b0;
        bus_if.start = 1'b1; bus_if.data_in = 8'hFF;
        tick();
        bus_if.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("t5_valid", 32'(bus_if.out_valid), 32'd0);
        chk("t5_busy",  32'(bus_if.busy),      32'd0);
        chk("t5_idx",   32'(bus_if.out_idx),   32'd0);
        chk("t5_data",  32'(bus_if.out_data),  32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5_nodone", 32'(bus_if.done), 32'd0);
        end
        tick();
        rst = 1'b0;
        tick();
        bus_if.start = 1'b1; bus_if.data_in = 8'hFF;
        tick();
        bus_if.start = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        chk("t5_idx6",  32'(bus_if.out_idx),  32'd6);
        chk("t5_entry6", 32'(bus_if.out_data), 32'h03);
        tick();
        wait_done("t5_done");

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 400; c++) begin
            bus_if.cfg_we    = ($urandom_range(0, 3) == 0);
            bus_if.cfg_addr  = 3'($urandom_range(0, 7));
            bus_if.cfg_wdata = 8'($urandom);
            bus_if.start     = ($urandom_range(0, 2) == 0);
            bus_if.data_in   = 8'($urandom);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus_if.cfg_we = 1'b0; bus_if.start = 1'b0; bus_if.out_ready = 1'b1;
        repeat (12) tick();

`ifdef MASK_TBL_PARITY_EN
        chk_en = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0; tick();
        force mask_tbl_seq.par_flip = 64'h1 << 24;
        bus_if.start = 1'b1; bus_if.data_in = 8'hFF;
        tick();
        bus_if.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("par_err", 32'(bus_if.err), 32'(k > 3));
            tick();
        end
        @(negedge clk);
        chk("par_sticky", 32'(bus_if.err), 32'd1);
        tick();
        release mask_tbl_seq.par_flip;
        rst = 1'b1; tick();
        chk("par_clear", 32'(bus_if.err), 32'd0);
        rst = 1'b0; tick();
        chk_en = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
